// File: rtl/mem_req_ctrl.sv
// Memory-stage data-bus request controller for the load/store path.
// Optional build macro: ADDR_ERR_EN (misaligned half/word raise AdEL/AdES).
package mem_req_pkg;
  localparam int ALUOP_BUS = 8;
  localparam int WORD_BUS  = 32;
  localparam int BSEL_BUS  = 4;

  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_ADD = 8'h18;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LB  = 8'h90;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LBU = 8'h91;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LH  = 8'h92;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LHU = 8'h93;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LW  = 8'h94;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_SB  = 8'h98;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_SH  = 8'h99;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_SW  = 8'h9a;
endpackage

module mem_req_ctrl
  import mem_req_pkg::*;
(
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  logic                 mem_valid_i,
  input  logic [ALUOP_BUS-1:0] mem_aluop_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          mem_din_i,
  input  logic                 flush_i,
  output logic                 data_req_o,
  output logic                 data_wr_o,
  output logic [1:0]           data_size_o,
  output logic [31:0]          data_addr_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_addr_ok_i,
  input  logic                 data_data_ok_i,
  input  logic [31:0]          data_rdata_i,
  output logic [WORD_BUS-1:0]  dm_o,
  output logic [BSEL_BUS-1:0]  dre_o,
  output logic                 mem_operation_ok_o,
  output logic                 stall_req_o,
  output logic                 exc_adel_o,
  output logic                 exc_ades_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, nxt;

  logic                is_ld, is_st, mem_op;
  logic [1:0]          sz;
  logic [BSEL_BUS-1:0] mask, lane_q;
  logic [31:0]         wdata;
  logic                misal, start, cap, discard;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sz    = 2'd0;
    case (mem_aluop_i)
      MINIMIPS32_LB,
      MINIMIPS32_LBU: is_ld = 1'b1;
      MINIMIPS32_LH,
      MINIMIPS32_LHU: begin
        is_ld = 1'b1;
        sz    = 2'd1;
      end
      MINIMIPS32_LW: begin
        is_ld = 1'b1;
        sz    = 2'd2;
      end
      MINIMIPS32_SB: is_st = 1'b1;
      MINIMIPS32_SH: begin
        is_st = 1'b1;
        sz    = 2'd1;
      end
      MINIMIPS32_SW: begin
        is_st = 1'b1;
        sz    = 2'd2;
      end
      default: ;
    endcase
  end

  assign mem_op = is_ld | is_st;

  always_comb begin
    mask  = 4'b1111;
    wdata = mem_din_i;
    unique case (1'b1)
      (sz == 2'd0): begin
        mask  = 4'b0001 << mem_addr_i[1:0];
        wdata = {4{mem_din_i[7:0]}};
      end
      (sz == 2'd1): begin
        mask  = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_din_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef ADDR_ERR_EN
  assign misal = ((sz == 2'd1) & mem_addr_i[0])
               | ((sz == 2'd2) & (mem_addr_i[1:0] != 2'b00));
  assign exc_adel_o = cpu_rst_n & (state == IDLE) & mem_valid_i
                    & is_ld & misal & ~flush_i;
  assign exc_ades_o = cpu_rst_n & (state == IDLE) & mem_valid_i
                    & is_st & misal & ~flush_i;
`else
  assign misal      = 1'b0;
  assign exc_adel_o = 1'b0;
  assign exc_ades_o = 1'b0;
`endif

  assign start = (state == IDLE) & mem_valid_i & mem_op
               & ~flush_i & ~misal;

  assign stall_req_o = cpu_rst_n
                     & (start | (state == REQ) | (state == WAIT));

  assign mem_operation_ok_o = cpu_rst_n
    & (((state == IDLE) & ~stall_req_o & ~exc_adel_o & ~exc_ades_o)
       | (state == DONE));

  assign data_req_o = (state == REQ);

  // A flush arriving together with data_ok still drops the result.
  assign cap = ((state == REQ) & ~flush_i & data_addr_ok_i & data_data_ok_i)
             | ((state == WAIT) & data_data_ok_i & ~discard & ~flush_i);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = REQ;
      REQ: begin
        if (flush_i)
          nxt = IDLE;
        else if (data_addr_ok_i & data_data_ok_i)
          nxt = DONE;
        else if (data_addr_ok_i)
          nxt = WAIT;
      end
      WAIT: begin
        if (data_data_ok_i)
          nxt = (discard | flush_i) ? IDLE : DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state        <= IDLE;
      discard      <= 1'b0;
      data_wr_o    <= 1'b0;
      data_size_o  <= 2'd0;
      data_addr_o  <= 32'd0;
      data_wdata_o <= 32'd0;
      lane_q       <= '0;
      dm_o         <= '0;
      dre_o        <= '0;
    end else begin
      state   <= nxt;
      discard <= (state == WAIT) & (discard | flush_i)
               & ~data_data_ok_i;
      if (start) begin
        data_wr_o    <= is_st;
        data_size_o  <= sz;
        data_addr_o  <= mem_addr_i;
        data_wdata_o <= wdata;
        lane_q       <= mask;
      end
      if (cap) begin
        dre_o <= data_wr_o ? 4'b0000 : lane_q;
        if (!data_wr_o)
          dm_o <= data_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a load/store result scoreboard.
// Build with +define+ADDR_ERR_EN to exercise the misaligned-access path.
module tb_mem_req_ctrl;
  import mem_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  op;
  logic [31:0] addr, din;
  logic        flush;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] baddr, bwdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [31:0] dm;
  logic [3:0]  dre;
  logic        ok, stall, adel, ades;

  typedef struct packed {
    logic [31:0] dm;
    logic [3:0]  dre;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .cpu_clk_50M       (clk),
    .cpu_rst_n         (rst_n),
    .mem_valid_i       (valid),
    .mem_aluop_i       (op),
    .mem_addr_i        (addr),
    .mem_din_i         (din),
    .flush_i           (flush),
    .data_req_o        (req),
    .data_wr_o         (wr),
    .data_size_o       (size),
    .data_addr_o       (baddr),
    .data_wdata_o      (bwdata),
    .data_addr_ok_i    (addr_ok),
    .data_data_ok_i    (data_ok),
    .data_rdata_i      (rdata),
    .dm_o              (dm),
    .dre_o             (dre),
    .mem_operation_ok_o(ok),
    .stall_req_o       (stall),
    .exc_adel_o        (adel),
    .exc_ades_o        (ades)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_dm"}, dm, e.dm);
    chk({tag, "_dre"}, {28'd0, dre}, {28'd0, e.dre});
  endtask

  // Drive just after the edge; checks follow after a short settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid   = 1'b0;
    op      = MINIMIPS32_ADD;
    flush   = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_in();
    addr  = 32'h0;
    din   = 32'h0;
    rdata = 32'h0;

    // reset: memory op present but everything held low
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_LW;
    cyc();
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ok", {31'd0, ok}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", baddr, 32'd0);
    chk("rst_dm", dm, 32'd0);
    chk("rst_dre", {28'd0, dre}, 32'd0);

    // LB at lane 3, single-cycle bus response
    cyc();
    rst_n = 1'b1;
    idle_in();
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_LB;
    addr  = 32'h8000_0003;
    sb.push_back('{dm: 32'hAABB_CCDD, dre: 4'b1000});
    #1;
    chk("lb_c0_stall", {31'd0, stall}, 32'd1);
    chk("lb_c0_ok", {31'd0, ok}, 32'd0);
    cyc();
    addr_ok = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'hAABB_CCDD;
    #1;
    chk("lb_c1_req", {31'd0, req}, 32'd1);
    chk("lb_c1_size", {30'd0, size}, 32'd0);
    chk("lb_c1_addr", baddr, 32'h8000_0003);
    chk("lb_c1_stall", {31'd0, stall}, 32'd1);
    cyc();
    addr_ok = 1'b0;
    data_ok = 1'b0;
    #1;
    chk("lb_c2_ok", {31'd0, ok}, 32'd1);
    chk("lb_c2_stall", {31'd0, stall}, 32'd0);
    sb_chk("lb");

    // SH: addr_ok after 3 wait cycles, data_ok 2 cycles later
    cyc();
    idle_in();
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_SH;
    addr  = 32'h8000_0002;
    din   = 32'h1234_5678;
    sb.push_back('{dm: 32'hAABB_CCDD, dre: 4'b0000});
    for (int i = 1; i <= 4; i++) begin
      cyc();
      addr_ok = (i == 4);
      #1;
      chk("sh_req", {31'd0, req}, 32'd1);
      chk("sh_wdata", bwdata, 32'h5678_5678);
      chk("sh_size", {30'd0, size}, 32'd1);
      chk("sh_wr", {31'd0, wr}, 32'd1);
      chk("sh_stall", {31'd0, stall}, 32'd1);
    end
    cyc();
    addr_ok = 1'b0;
    #1;
    chk("sh_wait_req", {31'd0, req}, 32'd0);
    chk("sh_wait_stall", {31'd0, stall}, 32'd1);
    cyc();
    data_ok = 1'b1;
    #1;
    chk("sh_dok_ok", {31'd0, ok}, 32'd0);
    cyc();
    data_ok = 1'b0;
    #1;
    chk("sh_done_ok", {31'd0, ok}, 32'd1);
    chk("sh_done_stall", {31'd0, stall}, 32'd0);
    sb_chk("sh");

    // LW flushed while waiting for data
    cyc();
    idle_in();
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_LW;
    addr  = 32'h8000_0010;
    cyc();
    addr_ok = 1'b1;
    #1;
    chk("fl_req", {31'd0, req}, 32'd1);
    cyc();
    addr_ok = 1'b0;
    flush   = 1'b1;
    #1;
    chk("fl_wait_ok", {31'd0, ok}, 32'd0);
    cyc();
    flush   = 1'b0;
    valid   = 1'b0;
    data_ok = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    #1;
    chk("fl_dok_ok", {31'd0, ok}, 32'd0);
    cyc();
    data_ok = 1'b0;
    #1;
    chk("fl_idle_stall", {31'd0, stall}, 32'd0);
    chk("fl_idle_req", {31'd0, req}, 32'd0);
    chk("fl_dm_kept", dm, 32'hAABB_CCDD);

    // LHU in the upper half
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_LHU;
    addr  = 32'h8000_0006;
    sb.push_back('{dm: 32'h0102_0304, dre: 4'b1100});
    cyc();
    addr_ok = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'h0102_0304;
    #1;
    chk("lh_size", {30'd0, size}, 32'd1);
    cyc();
    addr_ok = 1'b0;
    data_ok = 1'b0;
    #1;
    chk("lh_ok", {31'd0, ok}, 32'd1);
    sb_chk("lh");

    // non-memory instruction commits immediately
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_ADD;
    #1;
    chk("add_stall", {31'd0, stall}, 32'd0);
    chk("add_ok", {31'd0, ok}, 32'd1);
    cyc();
    #1;
    chk("add_req", {31'd0, req}, 32'd0);

    // reset during REQ, then a stray data_ok
    cyc();
    op   = MINIMIPS32_LW;
    addr = 32'h8000_0020;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rm_req", {31'd0, req}, 32'd1);
    cyc();
    valid = 1'b0;
    #1;
    chk("rm_req0", {31'd0, req}, 32'd0);
    chk("rm_addr0", baddr, 32'd0);
    chk("rm_wr0", {31'd0, wr}, 32'd0);
    chk("rm_dm0", dm, 32'd0);
    chk("rm_stall0", {31'd0, stall}, 32'd0);
    chk("rm_ok0", {31'd0, ok}, 32'd0);
    cyc();
    rst_n   = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'h1111_1111;
    cyc();
    data_ok = 1'b0;
    #1;
    chk("rm_stray_dm", dm, 32'd0);
    chk("rm_stray_ok", {31'd0, ok}, 32'd1);
    chk("rm_stray_req", {31'd0, req}, 32'd0);

    // misaligned LW
    cyc();
    valid = 1'b1;
    op    = MINIMIPS32_LW;
    addr  = 32'h8000_0001;
`ifdef ADDR_ERR_EN
    #1;
    chk("mis_adel", {31'd0, adel}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_ok", {31'd0, ok}, 32'd0);
    cyc();
    valid = 1'b0;
    #1;
    chk("mis_req", {31'd0, req}, 32'd0);
`else
    sb.push_back('{dm: 32'hCAFE_F00D, dre: 4'b1111});
    #1;
    chk("mis_adel", {31'd0, adel}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd1);
    cyc();
    addr_ok = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'hCAFE_F00D;
    #1;
    chk("mis_req", {31'd0, req}, 32'd1);
    chk("mis_addr", baddr, 32'h8000_0001);
    cyc();
    addr_ok = 1'b0;
    data_ok = 1'b0;
    #1;
    chk("mis_ok", {31'd0, ok}, 32'd1);
    sb_chk("mis");
`endif
    cyc();
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
